// File: rtl/glay_memory_pkg.sv
// Shared GLay memory types: request packet and cache arbiter FSM states.
package glay_memory_pkg;

  localparam int CACHE_ARB_MAX_OUTSTANDING = 16;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SEND
  } cache_arb_state_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  cmd;
    logic [31:0] addr;
    logic [7:0]  tag;
  } MemoryRequestPacket;

endpackage

// File: rtl/cache_request_arbiter_rr.sv
// rr_priority_select: first valid requester at or after a pointer,
// wrapping at N; one-hot grant, binary index and any-valid flag.
module rr_priority_select #(
  parameter int N = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          any
);

  logic [IW-1:0] j;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    j     = ptr;
    for (int k = 0; k < N; k++) begin
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        index    = j;
      end
      j = (j == IW'(N - 1)) ? '0 : j + 1'b1;
    end
  end

endmodule

// File: rtl/cache_request_arbiter.sv
// Round-robin cache request arbiter with grant hold and in-flight cap.
// Optional stats counters: define CACHE_ARB_STATS_EN.
module cache_request_arbiter
  import glay_memory_pkg::*;
#(
  parameter int NUM_MODULES = 3,
  parameter int MAX_OUTSTANDING = CACHE_ARB_MAX_OUTSTANDING,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1,
  localparam int IW = $clog2(NUM_MODULES)
) (
  input  logic               ap_clk,
  input  logic               areset_n,
  input  logic               enable_in,
  input  MemoryRequestPacket req_in [NUM_MODULES],
  output logic [NUM_MODULES-1:0] req_ready_out,
  output MemoryRequestPacket cache_req_out,
  input  logic               cache_ready_in,
  input  logic               resp_done_in,
  output logic [CNT_W-1:0]   outstanding_out,
`ifdef CACHE_ARB_STATS_EN
  output logic [31:0]        grant_count_out [NUM_MODULES],
  output logic [31:0]        stall_count_out,
`endif
  output logic               idle_out
);

  cache_arb_state_t state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;
  logic [IW-1:0] ptr_inc;
  logic [IW-1:0] sel_ptr;
  logic [IW-1:0] sel_idx;
  logic [NUM_MODULES-1:0] vld;
  logic [NUM_MODULES-1:0] sel_grant;
  logic          sel_any;
  logic          accept;
  logic          go_arb;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    vld = '0;
    for (int i = 0; i < NUM_MODULES; i++) vld[i] = req_in[i].valid;
  end

  assign accept  = (state == SEND) && cache_ready_in;
  assign ptr_inc = (gidx == IW'(NUM_MODULES - 1)) ? '0 : gidx + 1'b1;
  // The pick made on accept already sees the advanced pointer.
  assign sel_ptr = accept ? ptr_inc : ptr;

  rr_priority_select #(.N(NUM_MODULES)) u_sel (
    .valid (vld),
    .ptr   (sel_ptr),
    .grant (sel_grant),
    .index (sel_idx),
    .any   (sel_any)
  );

  always_comb begin
    cnt_next = outstanding_out;
    if (accept && !resp_done_in)
      cnt_next = outstanding_out + 1'b1;
    else if (!accept && resp_done_in && outstanding_out != '0)
      cnt_next = outstanding_out - 1'b1;
  end

  assign go_arb = enable_in && sel_any &&
                  (cnt_next < CNT_W'(MAX_OUTSTANDING));

  assign idle_out = (state == IDLE) && (outstanding_out == '0) &&
                    !cache_req_out.valid;

  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      state           <= IDLE;
      ptr             <= '0;
      gidx            <= '0;
      req_ready_out   <= '0;
      cache_req_out   <= '0;
      outstanding_out <= '0;
    end else begin
      outstanding_out <= cnt_next;
      req_ready_out   <= '0;
      unique case (state)
        IDLE: begin
          if (go_arb) begin
            state         <= ARB;
            gidx          <= sel_idx;
            req_ready_out <= sel_grant;
          end
        end
        ARB: begin
          // A requester that withdrew during its grant cycle transfers nothing.
          if (req_in[gidx].valid) begin
            cache_req_out <= req_in[gidx];
            state         <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (cache_ready_in) begin
            cache_req_out.valid <= 1'b0;
            ptr                 <= ptr_inc;
            if (go_arb) begin
              state         <= ARB;
              gidx          <= sel_idx;
              req_ready_out <= sel_grant;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_ARB_STATS_EN
  always_ff @(posedge ap_clk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_MODULES; i++) grant_count_out[i] <= '0;
      stall_count_out <= '0;
    end else begin
      if (accept) grant_count_out[gidx] <= grant_count_out[gidx] + 1'b1;
      if (state == SEND && !cache_ready_in)
        stall_count_out <= stall_count_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_request_arbiter.sv
// Directed bench for cache_request_arbiter: per-cycle vector table plus
// hand sequences for async reset mid-packet and pointer reset.
module tb_cache_request_arbiter;
  import glay_memory_pkg::*;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  logic enable_in = 1'b0;
  MemoryRequestPacket req [3];
  logic [2:0] req_ready_out;
  MemoryRequestPacket cache_req_out;
  logic cache_ready_in = 1'b0;
  logic resp_done_in = 1'b0;
  logic [2:0] outstanding_out;
  logic idle_out;
`ifdef CACHE_ARB_STATS_EN
  logic [31:0] grant_count_out [3];
  logic [31:0] stall_count_out;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_request_arbiter #(
    .NUM_MODULES(3),
    .MAX_OUTSTANDING(4)
  ) dut (
    .ap_clk          (clk),
    .areset_n        (areset_n),
    .enable_in       (enable_in),
    .req_in          (req),
    .req_ready_out   (req_ready_out),
    .cache_req_out   (cache_req_out),
    .cache_ready_in  (cache_ready_in),
    .resp_done_in    (resp_done_in),
    .outstanding_out (outstanding_out),
`ifdef CACHE_ARB_STATS_EN
    .grant_count_out (grant_count_out),
    .stall_count_out (stall_count_out),
`endif
    .idle_out        (idle_out)
  );

  typedef struct {
    logic       en;
    logic [2:0] v;
    logic       rdy;
    logic       done;
    logic [2:0] rr;
    logic       ov;
    logic [7:0] tag;
    logic [2:0] cnt;
    logic       idle;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic en, logic [2:0] v, logic rdy,
                              logic done, logic [2:0] rr, logic ov,
                              logic [7:0] tag, logic [2:0] cnt,
                              logic idle);
    vec_t r;
    r.en = en; r.v = v; r.rdy = rdy; r.done = done;
    r.rr = rr; r.ov = ov; r.tag = tag; r.cnt = cnt; r.idle = idle;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_valid(logic [2:0] v);
    for (int i = 0; i < 3; i++) req[i].valid = v[i];
  endtask

  task automatic wait_ov(string name);
    for (int i = 0; i < 10 && !cache_req_out.valid; i++) @(negedge clk);
    chk(name, {31'b0, cache_req_out.valid}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i].valid = 1'b0;
      req[i].cmd   = 2'(i);
      req[i].addr  = 32'h1000 + 32'(i) * 32'h40;
      req[i].tag   = 8'hA0 + 8'(i);
    end

    // en v rdy done | rr ov tag cnt idle
    tbl.push_back(mk(1, 3'b001, 1, 0, 3'b000, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 3'b001, 1, 0, 3'b001, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 3'b000, 1, 0, 3'b000, 1, 8'hA0, 0, 0));
    tbl.push_back(mk(1, 3'b000, 1, 1, 3'b000, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b000, 0, 8'h00, 0, 1));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b010, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b000, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(1, 3'b111, 1, 1, 3'b100, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b000, 1, 8'hA2, 0, 0));
    tbl.push_back(mk(1, 3'b111, 1, 1, 3'b001, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b000, 1, 8'hA0, 0, 0));
    tbl.push_back(mk(1, 3'b111, 1, 1, 3'b010, 0, 8'h00, 1, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 3'b111, 0, 0, 3'b000, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b000, 1, 8'hA1, 0, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b100, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b000, 1, 8'hA2, 1, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b001, 0, 8'h00, 2, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b000, 1, 8'hA0, 2, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b010, 0, 8'h00, 3, 0));
    tbl.push_back(mk(1, 3'b111, 1, 1, 3'b000, 1, 8'hA1, 3, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b100, 0, 8'h00, 3, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b000, 1, 8'hA2, 3, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b000, 0, 8'h00, 4, 0));
    tbl.push_back(mk(1, 3'b111, 1, 1, 3'b000, 0, 8'h00, 4, 0));
    tbl.push_back(mk(1, 3'b111, 1, 0, 3'b001, 0, 8'h00, 3, 0));
    tbl.push_back(mk(0, 3'b111, 1, 1, 3'b000, 1, 8'hA0, 3, 0));
    tbl.push_back(mk(0, 3'b111, 1, 1, 3'b000, 0, 8'h00, 3, 0));
    tbl.push_back(mk(0, 3'b111, 1, 1, 3'b000, 0, 8'h00, 2, 0));
    tbl.push_back(mk(0, 3'b111, 1, 1, 3'b000, 0, 8'h00, 1, 0));
    tbl.push_back(mk(0, 3'b111, 1, 1, 3'b000, 0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 3'b000, 1, 0, 3'b000, 0, 8'h00, 0, 1));

    #22 areset_n = 1'b1;

    foreach (tbl[k]) begin
      @(posedge clk);
      #1;
      enable_in      = tbl[k].en;
      drive_valid(tbl[k].v);
      cache_ready_in = tbl[k].rdy;
      resp_done_in   = tbl[k].done;
      @(negedge clk);
      chk($sformatf("c%0d ready", k), 32'(req_ready_out), 32'(tbl[k].rr));
      chk($sformatf("c%0d valid", k), 32'(cache_req_out.valid), 32'(tbl[k].ov));
      chk($sformatf("c%0d count", k), 32'(outstanding_out), 32'(tbl[k].cnt));
      chk($sformatf("c%0d idle", k), 32'(idle_out), 32'(tbl[k].idle));
      if (tbl[k].ov)
        chk($sformatf("c%0d tag", k), 32'(cache_req_out.tag), 32'(tbl[k].tag));
    end

    // Stalled SEND with one request in flight, then async reset.
    @(posedge clk);
    #1;
    enable_in      = 1'b1;
    drive_valid(3'b010);
    cache_ready_in = 1'b0;
    resp_done_in   = 1'b0;
    wait_ov("send1 timeout");
    @(posedge clk);
    #1 cache_ready_in = 1'b1;
    @(posedge clk);
    #1 cache_ready_in = 1'b0;
    wait_ov("send2 timeout");
    chk("pre-rst count", 32'(outstanding_out), 32'd1);
    chk("pre-rst tag", 32'(cache_req_out.tag), 32'hA1);
`ifdef CACHE_ARB_STATS_EN
    chk("gc0", grant_count_out[0], 32'd4);
    chk("gc1", grant_count_out[1], 32'd4);
    chk("gc2", grant_count_out[2], 32'd3);
`endif
    #2 areset_n = 1'b0;
    #1;
    chk("rst valid", 32'(cache_req_out.valid), 32'd0);
    chk("rst payload", 32'(cache_req_out.addr), 32'd0);
    chk("rst count", 32'(outstanding_out), 32'd0);
    chk("rst ready", 32'(req_ready_out), 32'd0);
    chk("rst idle", 32'(idle_out), 32'd1);
`ifdef CACHE_ARB_STATS_EN
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst gc%0d", i), grant_count_out[i], 32'd0);
    chk("rst stall", stall_count_out, 32'd0);
`endif
    drive_valid(3'b111);
    @(negedge clk);
    areset_n = 1'b1;
    @(negedge clk);
    chk("ptr after rst", 32'(req_ready_out), 32'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
